// File: rtl/fft_bfly_sched.sv
// fft_bfly_sched -- control sequencer for an in-place radix-2 DIT FFT that
// shares one pipelined butterfly unit and a dual-port sample RAM.
//
// Each stage issues N/2 butterflies on consecutive cycles. It then idles for
// BFLY_LAT cycles so that the last write-back of the stage lands before the
// next stage reads. Write-back addresses are the read addresses delayed by
// BFLY_LAT cycles.
//
// Optional build macro: FFT_BITREV_LOAD_EN. When it is defined, a LOAD state
// accepts N input samples and writes them at bit-reversed addresses before the
// first stage. When it is undefined, the RAM must already hold bit-reversed data.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, abort           host control (start is sampled only in IDLE)
//   busy, done             status; done is a one-cycle pulse after the final write
//   stage                  current stage index
//   rd_en                  butterfly issue strobe / RAM read enable
//   rd_addr_a/b, tw_idx    operand addresses and twiddle index (valid with rd_en)
//   wr_en, wr_addr_a/b     write-back strobe and addresses
//   in_valid, in_ready     sample load handshake (FFT_BITREV_LOAD_EN only)
module fft_bfly_sched #(
  parameter int N_LOG2   = 4,
  parameter int BFLY_LAT = 3,
  parameter int ADDR_W   = N_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
`ifdef FFT_BITREV_LOAD_EN
  input  logic              in_valid,
  output logic              in_ready,
`endif
  output logic              busy,
  output logic              done,
  output logic [2:0]        stage,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-2:0] tw_idx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b
);

  localparam int N       = 1 << N_LOG2;
  localparam int BF_W    = ADDR_W - 1;
  localparam int DRAIN_W = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;

  state_t              state_reg;
  logic                busy_reg, done_reg, rd_en_reg;
  logic [2:0]          stage_reg;
  logic [BF_W-1:0]     bfly_reg;
  logic [DRAIN_W-1:0]  drain_reg;
  logic [ADDR_W-1:0]   rd_a_reg, rd_b_reg;
  logic [BF_W-1:0]     tw_reg;
`ifdef FFT_BITREV_LOAD_EN
  logic [ADDR_W-1:0]   load_cnt_reg;
`endif

  // Any non-idle abort (or reset) empties the write-back pipeline.
  logic flush;
  assign flush = rst || (abort && state_reg != IDLE);

  // Butterfly addressing for stage s, butterfly b.
  function automatic logic [ADDR_W-1:0] addr_a_f(input logic [2:0] s, input logic [BF_W-1:0] b);
    int unsigned half, grp, pos;
    half = 32'd1 << s;
    grp  = 32'(b) >> s;
    pos  = 32'(b) & (half - 32'd1);
    return ADDR_W'((grp << (32'(s) + 32'd1)) | pos);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_b_f(input logic [2:0] s, input logic [BF_W-1:0] b);
    return addr_a_f(s, b) + ADDR_W'(32'd1 << s);
  endfunction

  function automatic logic [BF_W-1:0] tw_f(input logic [2:0] s, input logic [BF_W-1:0] b);
    int unsigned pos;
    pos = 32'(b) & ((32'd1 << s) - 32'd1);
    return BF_W'(pos << (N_LOG2 - 1 - int'(s)));
  endfunction

  // launch: the following cycle is an issue cycle for (launch_s, launch_b).
  logic            launch;
  logic [2:0]      launch_s;
  logic [BF_W-1:0] launch_b;

  always_comb begin
    launch   = 1'b0;
    launch_s = stage_reg;
    launch_b = '0;
    case (state_reg)
`ifndef FFT_BITREV_LOAD_EN
      IDLE: if (start) begin
        launch   = 1'b1;
        launch_s = 3'd0;
      end
`else
      LOAD: if (in_valid && load_cnt_reg == ADDR_W'(N - 1)) begin
        launch   = 1'b1;
        launch_s = 3'd0;
      end
`endif
      ISSUE: if (bfly_reg != BF_W'(N / 2 - 1)) begin
        launch   = 1'b1;
        launch_b = bfly_reg + 1'b1;
      end
      DRAIN: if (drain_reg == DRAIN_W'(BFLY_LAT - 1) && stage_reg != 3'(N_LOG2 - 1)) begin
        launch   = 1'b1;
        launch_s = stage_reg + 3'd1;
      end
      default: ;
    endcase
    if (abort) launch = 1'b0;
  end

  // Control FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      drain_reg <= '0;
`ifdef FFT_BITREV_LOAD_EN
      load_cnt_reg <= '0;
`endif
    end else if (abort && state_reg != IDLE) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (start && !abort) begin
          busy_reg <= 1'b1;
`ifdef FFT_BITREV_LOAD_EN
          state_reg    <= LOAD;
          load_cnt_reg <= '0;
`else
          state_reg <= ISSUE;
`endif
        end
`ifdef FFT_BITREV_LOAD_EN
        LOAD: if (in_valid) begin
          load_cnt_reg <= load_cnt_reg + 1'b1;
          if (load_cnt_reg == ADDR_W'(N - 1)) state_reg <= ISSUE;
        end
`endif
        ISSUE: if (bfly_reg == BF_W'(N / 2 - 1)) begin
          state_reg <= DRAIN;
          drain_reg <= '0;
        end
        DRAIN: begin
          if (drain_reg == DRAIN_W'(BFLY_LAT - 1)) begin
            if (stage_reg == 3'(N_LOG2 - 1)) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ISSUE;
            end
          end else begin
            drain_reg <= drain_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Issue-side registers. The address registers hold between issue cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_reg <= 1'b0;
      stage_reg <= '0;
      bfly_reg  <= '0;
      rd_a_reg  <= '0;
      rd_b_reg  <= '0;
      tw_reg    <= '0;
    end else begin
      rd_en_reg <= launch;
      if (launch) begin
        stage_reg <= launch_s;
        bfly_reg  <= launch_b;
        rd_a_reg  <= addr_a_f(launch_s, launch_b);
        rd_b_reg  <= addr_b_f(launch_s, launch_b);
        tw_reg    <= tw_f(launch_s, launch_b);
      end
    end
  end

  // Write-back delay line: BFLY_LAT stages carrying {en, addr_a, addr_b}.
  logic              pipe_en [BFLY_LAT];
  logic [ADDR_W-1:0] pipe_a  [BFLY_LAT];
  logic [ADDR_W-1:0] pipe_b  [BFLY_LAT];

  generate
    for (genvar gi = 0; gi < BFLY_LAT; gi++) begin : g_wpipe
      logic              src_en;
      logic [ADDR_W-1:0] src_a, src_b;
      if (gi == 0) begin : g_head
        assign src_en = rd_en_reg;
        assign src_a  = rd_a_reg;
        assign src_b  = rd_b_reg;
      end else begin : g_tail
        assign src_en = pipe_en[gi-1];
        assign src_a  = pipe_a[gi-1];
        assign src_b  = pipe_b[gi-1];
      end
      always_ff @(posedge clk) begin
        if (flush) begin
          pipe_en[gi] <= 1'b0;
          pipe_a[gi]  <= '0;
          pipe_b[gi]  <= '0;
        end else begin
          pipe_en[gi] <= src_en;
          pipe_a[gi]  <= src_a;
          pipe_b[gi]  <= src_b;
        end
      end
    end
  endgenerate

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign stage     = stage_reg;
  assign rd_en     = rd_en_reg;
  assign rd_addr_a = rd_a_reg;
  assign rd_addr_b = rd_b_reg;
  assign tw_idx    = tw_reg;

`ifdef FFT_BITREV_LOAD_EN
  // Bit-reversed placement of loaded samples. The butterfly pipe is empty in LOAD.
  function automatic logic [ADDR_W-1:0] bitrev_f(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = v[ADDR_W-1-i];
    return r;
  endfunction

  assign in_ready  = (state_reg == LOAD);
  assign wr_en     = (state_reg == LOAD) ? in_valid : pipe_en[BFLY_LAT-1];
  assign wr_addr_a = (state_reg == LOAD) ? bitrev_f(load_cnt_reg) : pipe_a[BFLY_LAT-1];
  assign wr_addr_b = (state_reg == LOAD) ? '0 : pipe_b[BFLY_LAT-1];
`else
  assign wr_en     = pipe_en[BFLY_LAT-1];
  assign wr_addr_a = pipe_a[BFLY_LAT-1];
  assign wr_addr_b = pipe_b[BFLY_LAT-1];
`endif

endmodule
